// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared constants and types for the pipeline sequencer.
//   - stall bit values and the five stall patterns written to pc_reg/if_id/...
//   - reset level, exception codes and FSM state encoding
package pipe_ctrl_pkg;

  // Stall bit meaning: 1 freezes the stage register.
  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  // Level of rst that resets the block.
  localparam logic RST_ENABLE = 1'b0;

  // Stall vectors, bit0 PC ... bit5 WB. A request freezes its own stage and
  // everything upstream of it.
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  // Exception codes delivered by the MEM stage.
  localparam logic [31:0] EXC_NONE    = 32'h00000000;
  localparam logic [31:0] EXC_INT     = 32'h00000001;
  localparam logic [31:0] EXC_SYSCALL = 32'h00000008;
  localparam logic [31:0] EXC_ERET    = 32'h0000000e;

  typedef enum logic [0:0] {
    ST_RUN        = 1'b0,
    ST_FLUSH_HOLD = 1'b1
  } state_e;

endpackage : pipe_ctrl_pkg

// File: rtl/pipe_ctrl_sat_counter.sv
// pipe_ctrl_sat_counter: up-counter that sticks at LIMIT.
//   clk   : clock
//   rst   : synchronous reset, active-low
//   inc   : count up by one this cycle (ignored at LIMIT)
//   clr   : return to zero this cycle (wins over inc)
//   count : current value
module pipe_ctrl_sat_counter
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned      WIDTH = 32,
  parameter logic [WIDTH-1:0] LIMIT = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_d, count_q;

  always_comb begin
    // NOTE: assigning a default first on every path keeps always_comb from inferring a latch.
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q < LIMIT)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule : pipe_ctrl_sat_counter

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central pipeline sequencer.
//   clk               : clock, rising edge
//   rst               : synchronous reset, active-low
//   stallreq_from_if  : instruction bus wait
//   stallreq_from_id  : load-use hazard
//   stallreq_from_ex  : multi-cycle mul/div/madd
//   stallreq_from_mem : data bus wait
//   excepttype_i      : exception code from MEM, 0 = none
//   cp0_epc_i         : EPC, redirect target for ERET
//   stall             : per-stage freeze vector (bit0 PC .. bit5 WB)
//   flush             : clear all pipeline registers
//   new_pc            : redirect target, valid while flush=1 (0 otherwise)
//   stall_cnt         : saturating count of stalled cycles
//   stall_timeout     : sticky flag, MEM stall lasted STALL_TIMEOUT cycles
// STALL_TIMEOUT must be at least 1; FLUSH_EXTRA is 0..7.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR    = 32'h00000020,
  parameter int unsigned FLUSH_EXTRA   = 1,
  parameter int unsigned STALL_TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_from_if,
  input  logic        stallreq_from_id,
  input  logic        stallreq_from_ex,
  input  logic        stallreq_from_mem,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic [31:0] stall_cnt,
  output logic        stall_timeout
);

  localparam int unsigned MEM_W = $clog2(STALL_TIMEOUT + 1);

  state_e      state_d, state_q;
  logic [2:0]  hold_cnt_d, hold_cnt_q;
  logic [31:0] new_pc_d, new_pc_q;
  logic        stall_timeout_d, stall_timeout_q;

  logic [31:0]      exc_target;
  logic             exc_now;
  logic             mem_inc, mem_clr;
  logic [MEM_W-1:0] mem_wait_cnt;

  assign exc_now    = (excepttype_i != EXC_NONE);
  assign exc_target = (excepttype_i == EXC_ERET) ? cp0_epc_i : EXC_VECTOR;

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    new_pc_d   = new_pc_q;
    stall      = STALL_NONE;
    flush      = 1'b0;
    new_pc     = '0;

    unique case (state_q)
      ST_RUN: begin
        if (exc_now) begin
          // Exception beats every stall request; redirect in this same cycle.
          flush    = 1'b1;
          new_pc   = exc_target;
          new_pc_d = exc_target;
          if (FLUSH_EXTRA > 0) begin
            hold_cnt_d = 3'(FLUSH_EXTRA);
            state_d    = ST_FLUSH_HOLD;
          end
        end else if (stallreq_from_mem) begin
          // Deepest requesting stage wins; patterns are not ORed together.
          stall = STALL_MEM;
        end else if (stallreq_from_ex) begin
          stall = STALL_EX;
        end else if (stallreq_from_id) begin
          stall = STALL_ID;
        end else if (stallreq_from_if) begin
          stall = STALL_IF;
        end
      end
      ST_FLUSH_HOLD: begin
        // Keep flushing fetches already in flight; new exceptions are ignored.
        flush      = 1'b1;
        new_pc     = new_pc_q;
        hold_cnt_d = hold_cnt_q - 3'd1;
        if (hold_cnt_q <= 3'd1) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase

    // Reset forces quiet outputs in the reset cycle itself, even mid-flush.
    if (rst == RST_ENABLE) begin
      stall  = STALL_NONE;
      flush  = 1'b0;
      new_pc = '0;
    end
  end

  // Watchdog: count consecutive MEM waits seen in RUN without an exception.
  assign mem_inc = (rst != RST_ENABLE) && (state_q == ST_RUN) && !exc_now
                   && stallreq_from_mem;
  assign mem_clr = !stallreq_from_mem || flush;

  // Flag is set on the edge where the counter reaches the limit.
  assign stall_timeout_d = stall_timeout_q
                           || (mem_inc && (mem_wait_cnt >= MEM_W'(STALL_TIMEOUT - 1)));

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q         <= ST_RUN;
      hold_cnt_q      <= '0;
      new_pc_q        <= '0;
      stall_timeout_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      hold_cnt_q      <= hold_cnt_d;
      new_pc_q        <= new_pc_d;
      stall_timeout_q <= stall_timeout_d;
    end
  end

  assign stall_timeout = stall_timeout_q;

  pipe_ctrl_sat_counter #(
    .WIDTH (32),
    .LIMIT (32'hFFFFFFFF)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall != STALL_NONE),
    .clr   (1'b0),
    .count (stall_cnt)
  );

  pipe_ctrl_sat_counter #(
    .WIDTH (MEM_W),
    .LIMIT (MEM_W'(STALL_TIMEOUT))
  ) u_mem_wait_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (mem_inc),
    .clr   (mem_clr),
    .count (mem_wait_cnt)
  );

endmodule : pipe_ctrl

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed bench for pipe_ctrl with FLUSH_EXTRA=2, STALL_TIMEOUT=4.
// Inputs change 1 time unit after a rising edge; combinational outputs are
// sampled at the falling edge, registered outputs 1 unit after the rising edge.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_if, req_id, req_ex, req_mem;
  logic [31:0] excepttype;
  logic [31:0] cp0_epc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic [31:0] stall_cnt;
  logic        stall_timeout;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(
    .EXC_VECTOR    (32'h00000020),
    .FLUSH_EXTRA   (2),
    .STALL_TIMEOUT (4)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .stallreq_from_if  (req_if),
    .stallreq_from_id  (req_id),
    .stallreq_from_ex  (req_ex),
    .stallreq_from_mem (req_mem),
    .excepttype_i      (excepttype),
    .cp0_epc_i         (cp0_epc),
    .stall             (stall),
    .flush             (flush),
    .new_pc            (new_pc),
    .stall_cnt         (stall_cnt),
    .stall_timeout     (stall_timeout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_req(input logic i_if, input logic i_id, input logic i_ex, input logic i_mem);
    req_if  = i_if;
    req_id  = i_id;
    req_ex  = i_ex;
    req_mem = i_mem;
  endtask

  // Advance to 1 unit after the next rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Stall-priority table: {if,id,ex,mem} and the expected stall vector.
  typedef struct {
    logic [3:0] req;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[5] = '{
    '{4'b1001, 6'b011111},   // IF + MEM -> MEM wins
    '{4'b0100, 6'b000111},   // ID only
    '{4'b1111, 6'b011111},   // all four -> MEM
    '{4'b1000, 6'b000011},   // IF only
    '{4'b0000, 6'b000000}    // nothing
  };

  initial begin
    rst        = 1'b0;
    excepttype = '0;
    cp0_epc    = '0;
    set_req(1'b0, 1'b0, 1'b0, 1'b1);

    // 1. Reset with a MEM request pending: everything quiet.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_stall", 32'(stall), 32'(0));
      check("rst_flush", 32'(flush), 32'(0));
      check("rst_new_pc", new_pc, 32'h0);
      next_cycle();
    end
    check("rst_stall_cnt", stall_cnt, 32'd0);
    check("rst_timeout", 32'(stall_timeout), 32'd0);
    rst = 1'b1;
    set_req(1'b0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    check("idle_stall_cnt", stall_cnt, 32'd0);

    // 2. ID + EX together for 3 cycles -> EX pattern.
    set_req(1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("id_ex_stall", 32'(stall), 32'(6'b001111));
      check("id_ex_flush", 32'(flush), 32'(0));
      next_cycle();
    end
    set_req(1'b0, 1'b0, 1'b0, 1'b0);
    check("id_ex_stall_cnt", stall_cnt, 32'd3);

    // Priority table; 4 of the 5 vectors stall.
    foreach (vecs[k]) begin
      set_req(vecs[k].req[3], vecs[k].req[2], vecs[k].req[1], vecs[k].req[0]);
      @(negedge clk);
      check($sformatf("prio_%0d", k), 32'(stall), 32'(vecs[k].exp));
      next_cycle();
    end
    set_req(1'b0, 1'b0, 1'b0, 1'b0);
    check("prio_stall_cnt", stall_cnt, 32'd7);

    // 3. SYSCALL with a MEM request: 3 flush cycles, second-cycle INT ignored.
    excepttype = EXC_SYSCALL;
    set_req(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("sys_flush_%0d", i), 32'(flush), 32'd1);
      check($sformatf("sys_new_pc_%0d", i), new_pc, 32'h00000020);
      check($sformatf("sys_stall_%0d", i), 32'(stall), 32'd0);
      next_cycle();
      excepttype = (i == 0) ? EXC_INT : EXC_NONE;
    end
    @(negedge clk);
    check("sys_resume_flush", 32'(flush), 32'd0);
    check("sys_resume_stall", 32'(stall), 32'(6'b011111));
    check("sys_resume_new_pc", new_pc, 32'h0);
    next_cycle();
    set_req(1'b0, 1'b0, 1'b0, 1'b0);
    check("sys_stall_cnt", stall_cnt, 32'd8);
    check("sys_timeout", 32'(stall_timeout), 32'd0);

    // 4. ERET redirects to EPC; the captured value holds while EPC moves.
    excepttype = EXC_ERET;
    cp0_epc    = 32'h00001234;
    @(negedge clk);
    check("eret_flush", 32'(flush), 32'd1);
    check("eret_new_pc", new_pc, 32'h00001234);
    next_cycle();
    excepttype = EXC_NONE;
    cp0_epc    = 32'h00005678;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check($sformatf("eret_hold_flush_%0d", i), 32'(flush), 32'd1);
      check($sformatf("eret_hold_pc_%0d", i), new_pc, 32'h00001234);
      next_cycle();
    end
    @(negedge clk);
    check("eret_done_flush", 32'(flush), 32'd0);
    next_cycle();
    check("eret_stall_cnt", stall_cnt, 32'd8);

    // 5. Watchdog: 4 consecutive MEM waits raise the sticky flag.
    set_req(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("wd_stall", 32'(stall), 32'(6'b011111));
      next_cycle();
      check($sformatf("wd_timeout_%0d", i), 32'(stall_timeout), (i == 3) ? 32'd1 : 32'd0);
    end
    set_req(1'b0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    check("wd_sticky", 32'(stall_timeout), 32'd1);
    check("wd_stall_cnt", stall_cnt, 32'd12);
    rst = 1'b0;
    next_cycle();
    check("wd_rst_timeout", 32'(stall_timeout), 32'd0);
    check("wd_rst_stall_cnt", stall_cnt, 32'd0);
    rst = 1'b1;
    next_cycle();

    // 6. Reset in the first FLUSH_HOLD cycle drops flush at once.
    excepttype = EXC_SYSCALL;
    @(negedge clk);
    check("rf_detect_flush", 32'(flush), 32'd1);
    next_cycle();
    excepttype = EXC_NONE;
    rst        = 1'b0;
    @(negedge clk);
    check("rf_rst_flush", 32'(flush), 32'd0);
    check("rf_rst_new_pc", new_pc, 32'h0);
    next_cycle();
    rst = 1'b1;
    set_req(1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("rf_run_stall", 32'(stall), 32'(6'b000011));
    check("rf_run_flush", 32'(flush), 32'd0);
    next_cycle();
    set_req(1'b0, 1'b0, 1'b0, 1'b0);
    check("rf_stall_cnt", stall_cnt, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_pipe_ctrl
